// File: rtl/ysyx_220053_mem_pkg.sv
// ysyx_220053_mem_pkg: types and helpers shared by the load/store unit and the memory responder.
package ysyx_220053_mem_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   localparam int MEM_DW = 64;
   localparam int MEM_MASKW = 8;
   typedef enum logic [1:0] {MOP_W = 2'b00, MOP_B = 2'b01, MOP_H = 2'b10, MOP_D = 2'b11} mop_size_t;
   typedef struct packed {
      logic      uns;
      mop_size_t size;
   } mem_op_t;
   function automatic logic [MEM_MASKW-1:0] mop_wmask(input mop_size_t size, input logic [2:0] off);
      return size == MOP_D ? 8'hFF :
             size == MOP_W ? 8'h0F << off :
             size == MOP_H ? 8'h03 << off : 8'h01 << off;
   endfunction
endpackage

// File: rtl/ysyx_220053_mem_array.sv
// ysyx_220053_mem_array: doubleword array with byte-masked synchronous write and registered read.
module ysyx_220053_mem_array
   import ysyx_220053_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  i_en,
   input  logic                  i_wen,
   input  logic [DEPTH_LOG2-1:0] i_idx,
   input  logic [MEM_DW-1:0]     i_wdata,
   input  logic [MEM_MASKW-1:0]  i_wmask,
   output logic [MEM_DW-1:0]     o_rdata
);
   logic [MEM_DW-1:0] r_mem [2**DEPTH_LOG2];
   logic [MEM_DW-1:0] r_rdata;
   assign o_rdata = r_rdata;
   always_ff @(posedge clk) begin
      if (i_en && i_wen) begin
         for (int b = 0; b < MEM_MASKW; b++)
            if (i_wmask[b]) r_mem[i_idx][8*b+:8] <= i_wdata[8*b+:8];
      end else if (i_en) begin
         r_rdata <= r_mem[i_idx];
      end
   end
endmodule

// File: rtl/ysyx_220053_mem_responder.sv
// ysyx_220053_mem_responder: data-memory responder with valid/ready request/response and fixed latency.
module ysyx_220053_mem_responder
   import ysyx_220053_mem_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter int          LATENCY    = 2,
   parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic [63:0]          i_req_addr,
   input  logic                 i_req_wen,
   input  logic [MEM_DW-1:0]    i_req_wdata,
   input  logic [MEM_MASKW-1:0] i_req_wmask,
   output logic                 o_resp_valid,
   input  logic                 i_resp_ready,
   output logic [MEM_DW-1:0]    o_resp_rdata,
   output logic                 o_resp_err
);
   localparam logic [63:0] SIZE = 64'(8) << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
   state_t r_state, w_next;
   logic [3:0] r_cnt;
   logic [63:0] r_addr;
   logic r_wen, r_rd_vld, r_err;
   logic [MEM_DW-1:0] r_wdata, w_wdata, w_arr_rdata;
   logic [MEM_MASKW-1:0] r_wmask, w_wmask;
   logic [63:0] w_addr, w_off;
   logic w_wen, w_accept, w_exec, w_hs, w_in;
   // With zero latency the access runs on the accept edge, straight from the request inputs.
   assign w_addr   = r_state == S_IDLE ? i_req_addr : r_addr;
   assign w_wen    = r_state == S_IDLE ? i_req_wen : r_wen;
   assign w_wdata  = r_state == S_IDLE ? i_req_wdata : r_wdata;
   assign w_wmask  = r_state == S_IDLE ? i_req_wmask : r_wmask;
   assign w_off    = w_addr - BASE_ADDR;
   assign w_in     = w_addr >= BASE_ADDR && w_off < SIZE;
   assign w_accept = i_req_valid && o_req_ready;
   assign w_exec   = (w_accept && LATENCY == 0) || (r_state == S_WAIT && r_cnt == 4'd0);
   assign w_hs     = r_state == S_RESP && i_resp_ready;
   assign o_resp_rdata = r_rd_vld ? w_arr_rdata : '0;
   assign o_resp_err   = r_err;
   always_comb begin
      o_req_ready  = r_state == S_IDLE;
      o_resp_valid = r_state == S_RESP;
      w_next = r_state == S_IDLE ? (w_accept ? (LATENCY == 0 ? S_RESP : S_WAIT) : S_IDLE) :
               r_state == S_WAIT ? (r_cnt == 4'd0 ? S_RESP : S_WAIT) :
               (i_resp_ready ? S_IDLE : S_RESP);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_rd_vld <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= i_req_addr;
            r_wen   <= i_req_wen;
            r_wdata <= i_req_wdata;
            r_wmask <= i_req_wmask;
            r_cnt   <= CNT_INIT;
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_exec) begin
            r_rd_vld <= w_in && !w_wen;
            r_err    <= !w_in;
         end else if (w_hs) begin
            r_rd_vld <= 1'b0;
            r_err    <= 1'b0;
         end
      end
   end
   ysyx_220053_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk     (clk),
      .i_en    (w_exec && w_in && !rst),
      .i_wen   (w_wen),
      .i_idx   (w_off[DEPTH_LOG2+2:3]),
      .i_wdata (w_wdata),
      .i_wmask (w_wmask),
      .o_rdata (w_arr_rdata)
   );
endmodule

// File: tb/tb_ysyx_220053_mem_responder.sv
// tb_ysyx_220053_mem_responder: directed checks on LATENCY=2, 3 and 0 builds of the responder.
module tb_ysyx_220053_mem_responder;
   localparam logic [63:0] B = 64'h0000_0000_8000_0000;
   logic clk = 0;
   logic rst [3];
   logic req_valid [3], req_ready [3], req_wen [3], resp_valid [3], resp_ready [3], resp_err [3];
   logic [63:0] req_addr [3], req_wdata [3], resp_rdata [3];
   logic [7:0] req_wmask [3];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      ysyx_220053_mem_responder #(.DEPTH_LOG2(10), .LATENCY(g == 0 ? 2 : (g == 1 ? 3 : 0)), .BASE_ADDR(B)) u_dut (
         .clk          (clk),
         .rst          (rst[g]),
         .i_req_valid  (req_valid[g]),
         .o_req_ready  (req_ready[g]),
         .i_req_addr   (req_addr[g]),
         .i_req_wen    (req_wen[g]),
         .i_req_wdata  (req_wdata[g]),
         .i_req_wmask  (req_wmask[g]),
         .o_resp_valid (resp_valid[g]),
         .i_resp_ready (resp_ready[g]),
         .o_resp_rdata (resp_rdata[g]),
         .o_resp_err   (resp_err[g])
      );
   end
   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic [63:0] rdata;
      logic        err;
   } vec_t;
   localparam int NV = 17;
   vec_t vt [NV];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic txn(input int d, input logic [63:0] a, input logic w, input logic [63:0] wd,
                      input logic [7:0] wm, output logic [63:0] rd, output logic er, output int lat);
      @(negedge clk);
      req_valid[d] = 1; req_addr[d] = a; req_wen[d] = w; req_wdata[d] = wd; req_wmask[d] = wm;
      @(posedge clk);
      #1 req_valid[d] = 0;
      lat = 0;
      forever begin
         @(negedge clk);
         if (resp_valid[d] || lat >= 40) break;
         lat++;
      end
      rd = resp_rdata[d];
      er = resp_err[d];
      resp_ready[d] = 1;
      @(posedge clk);
      #1 resp_ready[d] = 0;
   endtask
   logic [63:0] rd;
   logic er;
   int lat, n;
   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1; req_valid[d] = 0; req_addr[d] = '0; req_wen[d] = 0;
         req_wdata[d] = '0; req_wmask[d] = '0; resp_ready[d] = 0;
      end
      vt[0]  = '{B + 64'h10,   1, 64'h1122334455667788, 8'hFF, 64'h0, 0};
      vt[1]  = '{B + 64'h8,    1, 64'h0,                8'hFF, 64'h0, 0};
      vt[2]  = '{B + 64'h10,   0, 64'h0,                8'h00, 64'h1122334455667788, 0};
      vt[3]  = '{B + 64'h8,    1, 64'hAAAABBBBCCCCDDDD, 8'h0F, 64'h0, 0};
      vt[4]  = '{B + 64'h8,    0, 64'h0,                8'h00, 64'h00000000CCCCDDDD, 0};
      vt[5]  = '{B,            1, 64'h5555555555555555, 8'hFF, 64'h0, 0};
      vt[6]  = '{64'h7FFFFFF8, 0, 64'h0,                8'h00, 64'h0, 1};
      vt[7]  = '{B + 64'h2000, 0, 64'h0,                8'h00, 64'h0, 1};
      vt[8]  = '{64'h7FFFFFF8, 1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1};
      vt[9]  = '{B + 64'h2000, 1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1};
      vt[10] = '{B,            0, 64'h0,                8'h00, 64'h5555555555555555, 0};
      vt[11] = '{B + 64'h1FF8, 1, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0};
      vt[12] = '{B + 64'h1FF8, 0, 64'h0,                8'h00, 64'h0123456789ABCDEF, 0};
      vt[13] = '{B + 64'h8,    1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 0};
      vt[14] = '{B + 64'h8,    1, 64'h1111111111111111, 8'hF0, 64'h0, 0};
      vt[15] = '{B + 64'h8,    0, 64'h0,                8'h00, 64'h11111111CCCCDDDD, 0};
      vt[16] = '{B + 64'h10,   0, 64'h0,                8'h00, 64'h1122334455667788, 0};
      repeat (2) @(posedge clk);
      #1 for (int d = 0; d < 3; d++) rst[d] = 0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset d%0d resp_valid", d), resp_valid[d], 0);
         chk($sformatf("reset d%0d req_ready", d), req_ready[d], 1);
         chk($sformatf("reset d%0d rdata", d), resp_rdata[d], 0);
         chk($sformatf("reset d%0d err", d), resp_err[d], 0);
      end
      for (int i = 0; i < NV; i++) begin
         txn(0, vt[i].addr, vt[i].wen, vt[i].wdata, vt[i].wmask, rd, er, lat);
         chk($sformatf("v%0d rdata", i), rd, vt[i].rdata);
         chk($sformatf("v%0d err", i), er, vt[i].err);
         chk($sformatf("v%0d latency", i), 64'(lat), 2);
      end
      // Response stall: a pending request must not be taken while the response waits.
      @(negedge clk);
      req_valid[0] = 1; req_addr[0] = B + 64'h10; req_wen[0] = 0;
      @(posedge clk);
      #1 req_addr[0] = B + 64'h8; req_wen[0] = 1; req_wdata[0] = '1; req_wmask[0] = 8'hFF;
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 40);
      chk("stall first valid", 64'(n), 3);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall%0d valid", k), resp_valid[0], 1);
         chk($sformatf("stall%0d rdata", k), resp_rdata[0], 64'h1122334455667788);
         chk($sformatf("stall%0d req_ready", k), req_ready[0], 0);
         @(negedge clk);
      end
      req_valid[0] = 0; resp_ready[0] = 1;
      @(posedge clk);
      #1 resp_ready[0] = 0;
      @(negedge clk);
      chk("post hs valid", resp_valid[0], 0);
      chk("post hs rdata", resp_rdata[0], 0);
      chk("post hs err", resp_err[0], 0);
      chk("post hs req_ready", req_ready[0], 1);
      txn(0, B + 64'h8, 0, 0, 0, rd, er, lat);
      chk("stall no write", rd, 64'h11111111CCCCDDDD);
      // Reset on the last wait cycle of a LATENCY=3 write: the write must not commit.
      txn(1, B + 64'h18, 1, 64'hDEADBEEF00C0FFEE, 8'hFF, rd, er, lat);
      chk("l3 latency", 64'(lat), 3);
      @(negedge clk);
      req_valid[1] = 1; req_addr[1] = B + 64'h18; req_wen[1] = 1; req_wdata[1] = 64'hCAFE; req_wmask[1] = 8'hFF;
      @(posedge clk);
      #1 req_valid[1] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("l3 in wait", resp_valid[1], 0);
      rst[1] = 1;
      @(posedge clk);
      #1 rst[1] = 0;
      @(negedge clk);
      chk("l3 rst valid", resp_valid[1], 0);
      chk("l3 rst req_ready", req_ready[1], 1);
      repeat (4) @(negedge clk);
      chk("l3 rst still idle", resp_valid[1], 0);
      txn(1, B + 64'h18, 0, 0, 0, rd, er, lat);
      chk("l3 old value", rd, 64'hDEADBEEF00C0FFEE);
      // Zero-latency build.
      txn(2, B + 64'h10, 1, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er, lat);
      chk("l0 write latency", 64'(lat), 0);
      txn(2, B + 64'h13, 0, 0, 0, rd, er, lat);
      chk("l0 read latency", 64'(lat), 0);
      chk("l0 rdata", rd, 64'h0F0E0D0C0B0A0908);
      chk("l0 err", er, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ysyx_220053_mem_responder.md
Name: ysyx_220053_mem_responder

Overview:
- Responder (slave) end of the data-memory port driven by the core's load/store unit.
- Accepts one doubleword-granular request at a time over a valid/ready handshake and performs a byte-masked write or a full 64-bit read on an internal array.
- Returns a response after a configurable latency. Sign/zero extension and sub-word extraction stay in the requester.
- Replaces the zero-latency DPI memory model, so the core can be exercised against realistic wait states.

Parameters:
- DEPTH_LOG2, 10: array holds 2^DEPTH_LOG2 doublewords.
- LATENCY, 2: wait cycles between accept and response; range 0..15.
- BASE_ADDR, 64'h0000_0000_8000_0000: byte address of array word 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_addr  in  64  byte address; bits [2:0] ignored.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  64  write data, doubleword-aligned lanes.
- req_wmask  in  8  byte enables; bit i enables wdata[8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  64  read data; 0 for writes and errors.
- resp_err  out  1  address outside the array.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Array contents are not reset.
  - Reset mid-operation abandons the latched request. A write not yet committed never commits.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, wen, wdata, wmask.
  - Next state is WAIT with counter=LATENCY-1 if LATENCY>0, otherwise the access executes this edge and the next state is RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==0, the access executes on that edge and the next state is RESP.
- Access execution (single edge):
  - Index = (addr-BASE_ADDR)[DEPTH_LOG2+2:3].
  - In range means BASE_ADDR <= addr < BASE_ADDR + 8·2^DEPTH_LOG2, evaluated with an unsigned 64-bit compare.
  - Read: resp_rdata <= array[index]; resp_err <= 0.
  - Write: only masked bytes update; resp_rdata <= 0; resp_err <= 0. wmask=0 still produces a normal response with no change.
  - Out of range: no array change; resp_rdata <= 0; resp_err <= 1.
- Latency: resp_valid rises exactly LATENCY+1 cycles after the accept edge.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On that handshake: resp_valid <= 0, resp_rdata <= 0, resp_err <= 0, next state IDLE.
  - resp_ready low stalls indefinitely.
- No accept in the same cycle as a response handshake. Minimum spacing between accepts is LATENCY+2 cycles.
- Request inputs are ignored when req_ready=0. The requester must hold them stable only until the accept edge.
- Read after write to the same word returns the merged data, because the write commits before the RESP state.

Decomposition:
- Shared package ysyx_220053_mem_pkg holds:
  - FSM state enum (IDLE/WAIT/RESP, 2 bits).
  - MEM_DW=64, MEM_MASKW=8.
  - The MemOp encoding shared with the load/store unit: bit2 = unsigned; [1:0] word/byte/half/double = 00/01/10/11.
  - The MemOp-to-wmask mapping, so requester and responder agree.
- One natural sub-module, ysyx_220053_mem_array:
  - Synchronous byte-masked write and registered read of 2^DEPTH_LOG2×64 bits.
  - The FSM lives in the parent.

Test Plan:
- Reset, then a read of BASE_ADDR+0x10 after preloading word 2 with 64'h1122334455667788, LATENCY=2 -> resp_valid high exactly 3 cycles after accept; rdata=64'h1122334455667788; err=0.
- Write addr BASE+0x8, wdata 64'hAAAA_BBBB_CCCC_DDDD, wmask 8'b0000_1111 over a word holding 0 -> response rdata=0; a subsequent read returns 64'h0000_0000_CCCC_DDDD.
- Read at 64'h7FFF_FFF8, then at BASE+8·1024 (DEPTH_LOG2=10) -> both give err=1 and rdata=0; the array is unchanged.
- resp_ready held low for 5 cycles in RESP -> resp_valid stays 1 with rdata stable, and req_ready=0 throughout, with req_valid held high and no second accept.
- rst asserted in WAIT of a write (LATENCY=3) -> resp_valid=0 next cycle, req_ready=1, and a read of the target word returns the old value.
- LATENCY=0 build: read accepted -> resp_valid the next cycle. Addr BASE+0x13 returns word 2 (low bits ignored).
